// File: rtl/lfsr_rand_arbiter.sv
// -----------------------------------------------------------------------------
// lfsr_rand_arbiter
//
// Shares one bit-serial LFSR among N_REQ requesters. A granted requester gets
// WIDTH consecutive LFSR output bits assembled into one random word, delivered
// on rand_o together with a one-cycle pulse on its own valid_o bit. Requesters
// are served round-robin so that a requester that was just served drops to
// lowest priority.
//
// Ports:
//   clk_i       system clock, all state on posedge
//   rst_ni      synchronous reset, active-low
//   req_i       level request per requester, held until its valid_o bit pulses
//   lfsr_bit_i  next-bit output of the external LFSR
//   lfsr_en_o   LFSR shift enable, high only while shifting
//   grant_o     one-hot owner of the current transaction, 0 when idle
//   valid_o     one-cycle pulse on the owner's bit when rand_o is updated
//   rand_o      last assembled random word (holds between transactions)
//   busy_o      high while a transaction is in progress (SHIFT or DONE)
// -----------------------------------------------------------------------------
module lfsr_rand_arbiter #(
  parameter int unsigned N_REQ = 4,
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic [N_REQ-1:0] req_i,
  input  logic             lfsr_bit_i,
  output logic             lfsr_en_o,
  output logic [N_REQ-1:0] grant_o,
  output logic [N_REQ-1:0] valid_o,
  output logic [WIDTH-1:0] rand_o,
  output logic             busy_o
);

  localparam int unsigned PTR_W = $clog2(N_REQ);
  localparam int unsigned CNT_W = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);
  localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(N_REQ - 1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } state_e;

  state_e             state_r;
  state_e             state_nxt_s;
  logic [N_REQ-1:0]   grant_r;
  logic [N_REQ-1:0]   valid_r;
  logic [WIDTH-1:0]   rand_r;
  // Only WIDTH-1 bits need to be kept: the last bit arrives straight from
  // lfsr_bit_i on the cycle the word is completed.
  logic [WIDTH-2:0]   acc_r;
  logic [WIDTH-1:0]   acc_full_s;
  logic [CNT_W-1:0]   cnt_r;
  logic [PTR_W-1:0]   ptr_r;
  logic [PTR_W-1:0]   gidx_r;
  logic [PTR_W-1:0]   pick_idx_s;
  logic               req_any_s;
  logic               last_bit_s;

  // Round-robin pick: first set request bit at or after ptr, wrapping.
  function automatic logic [PTR_W-1:0] rr_pick(input logic [N_REQ-1:0] req,
                                               input logic [PTR_W-1:0] ptr);
    logic [PTR_W-1:0] idx;
    logic             found;
    int unsigned      pos;
    idx   = '0;
    found = 1'b0;
    for (int unsigned i = 0; i < N_REQ; i++) begin
      pos = (int'(ptr) + i) % N_REQ;
      if (!found && req[pos]) begin
        idx   = PTR_W'(pos);
        found = 1'b1;
      end else begin
        idx   = idx;
      end
    end
    return idx;
  endfunction

  // Request decode, shift-word assembly and last-bit detect.
  always_comb begin
    req_any_s  = |req_i;
    pick_idx_s = rr_pick(req_i, ptr_r);
    acc_full_s = {acc_r, lfsr_bit_i};
    last_bit_s = (cnt_r == CNT_LAST);
  end

  // Next-state logic.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (req_any_s) begin
          state_nxt_s = ST_SHIFT;
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_SHIFT: begin
        if (last_bit_s) begin
          state_nxt_s = ST_DONE;
        end else begin
          state_nxt_s = ST_SHIFT;
        end
      end
      ST_DONE:  state_nxt_s = ST_IDLE;
      default:  state_nxt_s = ST_IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Grant, accumulator, counter, pointer and result registers.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      grant_r <= '0;
      valid_r <= '0;
      rand_r  <= '0;
      acc_r   <= '0;
      cnt_r   <= '0;
      ptr_r   <= '0;
      gidx_r  <= '0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          valid_r <= '0;
          if (req_any_s) begin
            grant_r <= {{(N_REQ-1){1'b0}}, 1'b1} << pick_idx_s;
            gidx_r  <= pick_idx_s;
            cnt_r   <= '0;
            acc_r   <= '0;
          end else begin
            grant_r <= '0;
          end
        end
        ST_SHIFT: begin
          // First captured bit ends up as the MSB of the word.
          acc_r <= acc_full_s[WIDTH-2:0];
          cnt_r <= cnt_r + CNT_W'(1);
          if (last_bit_s) begin
            rand_r  <= acc_full_s;
            valid_r <= grant_r;
          end else begin
            valid_r <= '0;
          end
        end
        ST_DONE: begin
          valid_r <= '0;
          grant_r <= '0;
          // Served requester becomes lowest priority.
          ptr_r   <= (gidx_r == PTR_LAST) ? '0 : gidx_r + PTR_W'(1);
        end
        default: begin
          valid_r <= '0;
          grant_r <= '0;
        end
      endcase
    end
  end

  assign lfsr_en_o = (state_r == ST_SHIFT);
  assign busy_o    = (state_r != ST_IDLE);
  assign grant_o   = grant_r;
  assign valid_o   = valid_r;
  assign rand_o    = rand_r;

endmodule

// File: tb/tb_lfsr_rand_arbiter.sv
// -----------------------------------------------------------------------------
// tb_lfsr_rand_arbiter
//
// Directed bench for lfsr_rand_arbiter (N_REQ=4, WIDTH=8). Provides an 8-bit
// bit-serial LFSR (next bit = ~(s7^s5^s4^s3), seeded to 0) as the shared
// random source, and checks reset behaviour, word values, latency,
// round-robin order, late/dropped requests and reset during a transaction.
// -----------------------------------------------------------------------------
module tb_lfsr_rand_arbiter;

  logic       clk;
  logic       rst_n;
  logic [3:0] req;
  logic       lfsr_bit;
  logic       lfsr_en;
  logic [3:0] grant;
  logic [3:0] valid;
  logic [7:0] rnd;
  logic       busy;

  int checks;
  int errors;
  int cyc;
  int en_cycles;

  logic       seed_load;
  logic [7:0] lfsr_q;
  logic [7:0] exp_acc;

  lfsr_rand_arbiter #(.N_REQ(4), .WIDTH(8)) dut (
    .clk_i      (clk),
    .rst_ni     (rst_n),
    .req_i      (req),
    .lfsr_bit_i (lfsr_bit),
    .lfsr_en_o  (lfsr_en),
    .grant_o    (grant),
    .valid_o    (valid),
    .rand_o     (rnd),
    .busy_o     (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Shared LFSR the arbiter drives.
  assign lfsr_bit = ~(lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]);
  always @(posedge clk) begin
    if (seed_load) lfsr_q <= 8'h00;
    else if (lfsr_en) lfsr_q <= {lfsr_q[6:0], lfsr_bit};
  end

  // Bits handed out while enabled; after 8 shifts this is the delivered word.
  always @(posedge clk) begin
    if (lfsr_en) begin
      exp_acc   <= {exp_acc[6:0], lfsr_bit};
      en_cycles <= en_cycles + 1;
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic wait_grant(output logic [3:0] g);
    logic found;
    found = 1'b0;
    g = 4'd0;
    for (int i = 0; i < 40 && !found; i++) begin
      tick();
      if (grant != 4'd0) begin
        found = 1'b1;
        g = grant;
      end
    end
    chk("grant_seen", {31'd0, found}, 32'd1);
  endtask

  task automatic wait_valid(output logic [3:0] v, output logic [7:0] r, output int n);
    logic found;
    found = 1'b0;
    v = 4'd0;
    r = 8'd0;
    n = 0;
    for (int i = 0; i < 40 && !found; i++) begin
      tick();
      n++;
      if (valid != 4'd0) begin
        found = 1'b1;
        v = valid;
        r = rnd;
      end
    end
    chk("valid_seen", {31'd0, found}, 32'd1);
  endtask

  initial begin
    logic [3:0] g;
    logic [3:0] v;
    logic [7:0] r;
    logic [3:0] ge;
    int         n;
    int         en0;
    int         prev_cyc;
    int         vc;

    checks    = 0;
    errors    = 0;
    cyc       = 0;
    en_cycles = 0;
    exp_acc   = 8'h00;
    lfsr_q    = 8'h00;
    seed_load = 1'b1;
    rst_n     = 1'b0;
    req       = 4'b1111;

    // Reset with all requests high.
    tick();
    tick();
    chk("rst_grant", {28'd0, grant}, 32'd0);
    chk("rst_valid", {28'd0, valid}, 32'd0);
    chk("rst_rand",  {24'd0, rnd},   32'd0);
    chk("rst_busy",  {31'd0, busy},  32'd0);
    chk("rst_en",    {31'd0, lfsr_en}, 32'd0);

    rst_n     = 1'b1;
    seed_load = 1'b0;
    req       = 4'b0000;
    for (int i = 0; i < 10; i++) begin
      tick();
      chk("idle_outs", {18'd0, grant, valid, rnd, busy, lfsr_en}, 32'd0);
    end

    // Single word from requester 0, LFSR seed 0.
    en0 = en_cycles;
    req = 4'b0001;
    wait_grant(g);
    chk("single_grant", {28'd0, g}, 32'h1);
    wait_valid(v, r, n);
    chk("single_valid", {28'd0, v}, 32'h1);
    chk("single_rand",  {24'd0, r}, 32'hF4);
    chk("single_lat",   n, 32'd8);
    chk("single_en_cnt", en_cycles - en0, 32'd8);

    // Back-to-back: requester 0 keeps holding.
    en0 = en_cycles;
    wait_grant(g);
    chk("b2b_grant", {28'd0, g}, 32'h1);
    wait_valid(v, r, n);
    chk("b2b_valid", {28'd0, v}, 32'h1);
    chk("b2b_rand",  {24'd0, r}, 32'h39);
    chk("b2b_en_cnt", en_cycles - en0, 32'd8);
    req = 4'b0000;
    tick();
    chk("valid_one_cycle", {28'd0, valid}, 32'd0);
    chk("grant_cleared",   {28'd0, grant}, 32'd0);
    chk("rand_holds",      {24'd0, rnd},   32'h39);

    // Round-robin from a fresh pointer with all requests held.
    rst_n = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
    req   = 4'b1111;
    prev_cyc = 0;
    for (int k = 0; k < 5; k++) begin
      ge = 4'b0001 << (k % 4);
      wait_grant(g);
      chk("rr_grant", {28'd0, g}, {28'd0, ge});
      wait_valid(v, r, n);
      chk("rr_valid", {28'd0, v}, {28'd0, ge});
      chk("rr_rand",  {24'd0, r}, {24'd0, exp_acc});
      if (k > 0) chk("rr_spacing", cyc - prev_cyc, 32'd10);
      prev_cyc = cyc;
    end
    req = 4'b0000;

    // Late raise of req[2] and drop of req[1] during requester 1's word.
    req = 4'b0010;
    wait_grant(g);
    chk("late_grant1", {28'd0, g}, 32'h2);
    tick();
    tick();
    tick();
    req = 4'b0100;
    wait_valid(v, r, n);
    chk("drop_valid", {28'd0, v}, 32'h2);
    chk("drop_rand",  {24'd0, r}, {24'd0, exp_acc});
    vc = cyc;
    wait_grant(g);
    chk("late_grant2", {28'd0, g}, 32'h4);
    chk("late_gap",    cyc - vc, 32'd2);
    wait_valid(v, r, n);
    chk("late_valid2", {28'd0, v}, 32'h4);
    req = 4'b0000;

    // Reset on the 4th enabled cycle of a transaction.
    req = 4'b0001;
    wait_grant(g);
    chk("abort_grant", {28'd0, g}, 32'h1);
    tick();
    tick();
    tick();
    chk("abort_in_shift", {31'd0, lfsr_en}, 32'd1);
    rst_n = 1'b0;
    req   = 4'b0000;
    tick();
    chk("abort_en",    {31'd0, lfsr_en}, 32'd0);
    chk("abort_grant0", {28'd0, grant}, 32'd0);
    chk("abort_valid", {28'd0, valid}, 32'd0);
    chk("abort_rand",  {24'd0, rnd},   32'd0);
    chk("abort_busy",  {31'd0, busy},  32'd0);
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("abort_no_valid", {27'd0, valid, lfsr_en}, 32'd0);
    end
    req = 4'b1010;
    wait_grant(g);
    chk("post_rst_grant", {28'd0, g}, 32'h2);
    wait_valid(v, r, n);
    chk("post_rst_valid", {28'd0, v}, 32'h2);
    chk("post_rst_rand",  {24'd0, r}, {24'd0, exp_acc});
    req = 4'b0000;
    tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
